// File: rtl/fifo_write_skid_feeder_pkg.sv
// Shared helpers for the FIFO write-side skid feeder.
package fifo_write_skid_feeder_pkg;

    localparam int STALL_WIDTH = 32;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STALL_WIDTH-1:0] satIncrement(input logic [STALL_WIDTH-1:0] value);
        return (value == {STALL_WIDTH{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_write_skid_feeder_skid_register_file.sv
// DEPTH x WIDTH storage for the skid buffer: one synchronous write port,
// one asynchronous read port. Contents are deliberately not reset.
module skid_register_file
    import fifo_write_skid_feeder_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = 2,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  writeEn,
    input  logic [ADDR_WIDTH-1:0] writeAddr,
    input  logic [WIDTH-1:0]      writeData,
    input  logic [ADDR_WIDTH-1:0] readAddr,
    output logic [WIDTH-1:0]      readData
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Store the incoming word at the write address.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= writeData;
        end
    end

    assign readData = mem[readAddr];

endmodule

// File: rtl/fifo_write_skid_feeder.sv
// Converts a valid/ready stream into a FIFO write port, throttled by the
// FIFO's registered almostFull flag. A small skid buffer absorbs words while
// the flag is high so inReady depends only on local registered state.
module fifo_write_skid_feeder
    import fifo_write_skid_feeder_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int SKID_DEPTH_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   inValid,
    input  logic [WIDTH-1:0]       inData,
    output logic                   inReady,
    input  logic                   almostFull,
    output logic                   writeEnable,
    output logic [WIDTH-1:0]       dataOut,
    output logic                   empty,
    output logic [STALL_WIDTH-1:0] stallCycles
);

    localparam int DEPTH = 1 << SKID_DEPTH_LOG2;
    localparam logic [SKID_DEPTH_LOG2:0] FULL_COUNT = (SKID_DEPTH_LOG2 + 1)'(DEPTH);

    logic [SKID_DEPTH_LOG2-1:0] wrPtr;
    logic [SKID_DEPTH_LOG2-1:0] rdPtr;
    logic [SKID_DEPTH_LOG2:0]   count;
    logic [WIDTH-1:0]           headData;
    logic                       push;
    logic                       pop;
    logic                       bufferBusy;

    // Ready comes from registered occupancy only; a pop in the same cycle
    // does not free a slot for a push.
    assign inReady    = (count != FULL_COUNT);
    assign bufferBusy = (count != '0);
    assign push       = inValid && inReady;
    assign pop        = bufferBusy && !almostFull;
    assign empty      = !bufferBusy && !writeEnable;

    skid_register_file #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (SKID_DEPTH_LOG2),
        .DEPTH      (DEPTH)
    ) skidMem (
        .clk       (clk),
        .writeEn   (push),
        .writeAddr (wrPtr),
        .writeData (inData),
        .readAddr  (rdPtr),
        .readData  (headData)
    );

    // Advance the circular pointers and track occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Registered write port; data is zeroed whenever no write is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeEnable <= 1'b0;
            dataOut     <= '0;
        end else begin
            writeEnable <= pop;
            dataOut     <= pop ? headData : '0;
        end
    end

    // Count cycles where buffered words are held back by almostFull.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCycles <= '0;
        end else if (bufferBusy && almostFull) begin
            stallCycles <= satIncrement(stallCycles);
        end
    end

endmodule
